mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller sitting on the consumer side of the EX/MEM pipeline register. It turns the latched EX/MEM control and data into single-cycle request pulses to the stallable data memory/cache and waits for completion. While the access is outstanding it stalls the upstream pipeline and inserts bubbles into MEM/WB. On completion it registers the MEM/WB stage, including read data and an access-error flag.

## Interface
- TIMEOUT, 15: maximum wait cycles after the request before the access is aborted with error (1..255).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_en_EX_MEM  in  1  instruction accesses data memory.
- mem_wr_EX_MEM  in  1  1 = store, 0 = load (qualified by mem_en).
- alu_out_EX_MEM  in  16  effective address / ALU result.
- r2_EX_MEM  in  16  store data.
- w1_reg_EX_MEM  in  3  destination register.
- reg_en_EX_MEM  in  1  register write enable.
- halt_EX_MEM  in  1  halt marker.
- mem_rd  out  1  read request pulse.
- mem_wr  out  1  write request pulse.
- mem_addr  out  16  request address (= alu_out_EX_MEM).
- mem_wdata  out  16  request write data (= r2_EX_MEM).
- mem_rdata  in  16  read data, valid when mem_done.
- mem_done  in  1  access complete (may be high in the request cycle on a hit).
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- w1_reg_MEM_WB  out  3; reg_en_MEM_WB  out  1; halt_MEM_WB  out  1.
- alu_out_MEM_WB  out  16; rdata_MEM_WB  out  16.
- mem_to_reg_MEM_WB  out  1  write-back selects rdata (completed load).
- err_MEM_WB  out  1  access error (misaligned or timeout).

## Operation
- States: IDLE, WAIT. Reset state IDLE.
- access = mem_en_EX_MEM & ~alu_out_EX_MEM[0]; misalign = mem_en_EX_MEM & alu_out_EX_MEM[0].
- IDLE: if access, drive mem_rd = ~mem_wr_EX_MEM or mem_wr = mem_wr_EX_MEM for this cycle only (combinational).
  - mem_done same cycle: complete, stay IDLE, stall_mem = 0.
  - else: go WAIT, stall_mem = 1, wait counter cleared to 0.
- IDLE, misalign: no request; instruction completes immediately with error.
- IDLE, no memory op: pass-through, no stall.
- WAIT: mem_rd/mem_wr low; counter increments each cycle.
  - mem_done: stall_mem = 0, complete, go IDLE.
  - counter reaches TIMEOUT with no mem_done: stall_mem = 0, complete with error, go IDLE.
  - mem_done and timeout in the same cycle: mem_done wins, no error.
- Completion (any cycle with stall_mem = 0): MEM/WB loads w1_reg, halt, alu_out. rdata is loaded from mem_rdata on a load done, else 0. mem_to_reg = completed load. err = misalign | timeout. reg_en = reg_en_EX_MEM & ~err.
- stall_mem = 1: MEM/WB loads a bubble (reg_en = 0, halt = 0, mem_to_reg = 0, err = 0, other fields 0).
- mem_done while in IDLE with no request: ignored.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, counter 0, all MEM/WB outputs 0. stall_mem, mem_rd, and mem_wr are 0 after reset.
- Hit latency: 0 stall cycles; MEM/WB valid one edge after the request cycle.
- Miss: stall_mem is high from the request cycle through the cycle before mem_done. An access with done N cycles after the request stalls N cycles.
- Timeout: stall lasts TIMEOUT+1 cycles including the request cycle.
- EX/MEM inputs are stable throughout a stall, since EX/MEM is frozen by stall_mem.
- Reset mid-WAIT aborts the access immediately. No MEM/WB write occurs for it.

## Test plan
- Load hit: mem_en = 1, wr = 0, addr = 0x0010, mem_done in the request cycle with rdata = 0xBEEF -> one mem_rd pulse, stall_mem never high. Next cycle rdata_MEM_WB = 0xBEEF, mem_to_reg = 1, reg_en = 1.
- Store miss: addr = 0x0020, wdata = 0x1234, done 3 cycles after the request -> one mem_wr pulse with the address and data. stall_mem high for 3 cycles, then MEM/WB has reg_en = 0 and err = 0; 3 bubbles precede it.
- Misaligned: addr = 0x0021, mem_en = 1 -> no request, no stall, err_MEM_WB = 1, reg_en_MEM_WB = 0.
- Timeout: TIMEOUT = 15, load with mem_done never asserted -> stall_mem high for 16 cycles, then err_MEM_WB = 1, rdata = 0, state IDLE.
- Async reset in WAIT after 2 cycles -> outputs 0 immediately. After release, a non-memory ALU op passes with alu_out_MEM_WB equal to the input and no stall.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one-cycle load/store requests from EX/MEM,
// stalls the front of the pipeline while the access is outstanding and registers MEM/WB.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_EX_MEM,
    input  logic        mem_wr_EX_MEM,
    input  logic [15:0] alu_out_EX_MEM,
    input  logic [15:0] r2_EX_MEM,
    input  logic [2:0]  w1_reg_EX_MEM,
    input  logic        reg_en_EX_MEM,
    input  logic        halt_EX_MEM,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall_mem,
    output logic [2:0]  w1_reg_MEM_WB,
    output logic        reg_en_MEM_WB,
    output logic        halt_MEM_WB,
    output logic [15:0] alu_out_MEM_WB,
    output logic [15:0] rdata_MEM_WB,
    output logic        mem_to_reg_MEM_WB,
    output logic        err_MEM_WB
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] cnt_r;
    logic       access_s;
    logic       misalign_s;
    logic       done_ok_s;
    logic       timeout_s;
    logic       cnt_clr_s;
    logic       cnt_inc_s;
    logic       err_s;
    logic       load_done_s;

    assign access_s    = mem_en_EX_MEM & ~alu_out_EX_MEM[0];
    assign misalign_s  = mem_en_EX_MEM &  alu_out_EX_MEM[0];
    assign mem_addr    = alu_out_EX_MEM;
    assign mem_wdata   = r2_EX_MEM;
    assign err_s       = misalign_s | timeout_s;
    assign load_done_s = done_ok_s & ~mem_wr_EX_MEM;

    // Next-state, request pulses and stall; everything held low while reset is asserted.
    always_comb begin
        state_nxt_s = state_r;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        stall_mem   = 1'b0;
        done_ok_s   = 1'b0;
        timeout_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        if (!rst) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s) begin
                        mem_rd = ~mem_wr_EX_MEM;
                        mem_wr =  mem_wr_EX_MEM;
                        if (mem_done) begin
                            done_ok_s = 1'b1;
                        end else begin
                            stall_mem   = 1'b1;
                            cnt_clr_s   = 1'b1;
                            state_nxt_s = WAIT;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                WAIT: begin
                    // A late done in the timeout cycle still counts as success.
                    if (mem_done) begin
                        done_ok_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (cnt_r == TIMEOUT_C) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        stall_mem   = 1'b1;
                        cnt_inc_s   = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait-cycle counter, cleared on the request cycle of a miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 8'd0;
        end else if (cnt_clr_s) begin
            cnt_r <= 8'd0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise the completed instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w1_reg_MEM_WB     <= 3'd0;
            reg_en_MEM_WB     <= 1'b0;
            halt_MEM_WB       <= 1'b0;
            alu_out_MEM_WB    <= 16'd0;
            rdata_MEM_WB      <= 16'd0;
            mem_to_reg_MEM_WB <= 1'b0;
            err_MEM_WB        <= 1'b0;
        end else if (stall_mem) begin
            w1_reg_MEM_WB     <= 3'd0;
            reg_en_MEM_WB     <= 1'b0;
            halt_MEM_WB       <= 1'b0;
            alu_out_MEM_WB    <= 16'd0;
            rdata_MEM_WB      <= 16'd0;
            mem_to_reg_MEM_WB <= 1'b0;
            err_MEM_WB        <= 1'b0;
        end else begin
            w1_reg_MEM_WB     <= w1_reg_EX_MEM;
            reg_en_MEM_WB     <= reg_en_EX_MEM & ~err_s;
            halt_MEM_WB       <= halt_EX_MEM;
            alu_out_MEM_WB    <= alu_out_EX_MEM;
            rdata_MEM_WB      <= load_done_s ? mem_rdata : 16'd0;
            mem_to_reg_MEM_WB <= load_done_s;
            err_MEM_WB        <= err_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus pushes expected MEM/WB records,
// a monitor pops them whenever the DUT completes an instruction.
module tb_mem_stage_ctrl;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_EX_MEM, mem_wr_EX_MEM, reg_en_EX_MEM, halt_EX_MEM;
    logic [15:0] alu_out_EX_MEM, r2_EX_MEM, mem_rdata;
    logic [2:0]  w1_reg_EX_MEM;
    logic        mem_done;
    logic        mem_rd, mem_wr, stall_mem;
    logic [15:0] mem_addr, mem_wdata;
    logic [2:0]  w1_reg_MEM_WB;
    logic        reg_en_MEM_WB, halt_MEM_WB, mem_to_reg_MEM_WB, err_MEM_WB;
    logic [15:0] alu_out_MEM_WB, rdata_MEM_WB;

    typedef struct {
        logic [2:0]  w1;
        logic        reg_en;
        logic        halt;
        logic [15:0] alu;
        logic [15:0] rdata;
        logic        m2r;
        logic        err;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_en_EX_MEM(mem_en_EX_MEM), .mem_wr_EX_MEM(mem_wr_EX_MEM),
        .alu_out_EX_MEM(alu_out_EX_MEM), .r2_EX_MEM(r2_EX_MEM),
        .w1_reg_EX_MEM(w1_reg_EX_MEM), .reg_en_EX_MEM(reg_en_EX_MEM),
        .halt_EX_MEM(halt_EX_MEM),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_mem(stall_mem),
        .w1_reg_MEM_WB(w1_reg_MEM_WB), .reg_en_MEM_WB(reg_en_MEM_WB),
        .halt_MEM_WB(halt_MEM_WB), .alu_out_MEM_WB(alu_out_MEM_WB),
        .rdata_MEM_WB(rdata_MEM_WB), .mem_to_reg_MEM_WB(mem_to_reg_MEM_WB),
        .err_MEM_WB(err_MEM_WB)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one instruction at posedge+2; memory answers 'lat' cycles after the request.
    task automatic issue(input logic en, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [2:0] w1, input logic ren,
                         input logic hlt, input int lat, input logic [15:0] rval);
        wb_t  e;
        int   exp_stall, stalls, rdp, wrp;
        logic acc, mis, stl;
        acc = en & ~addr[0];
        mis = en & addr[0];
        e.w1 = w1; e.halt = hlt; e.alu = addr; e.rdata = 16'd0; e.m2r = 1'b0; e.err = 1'b0;
        exp_stall = 0;
        if (mis) begin
            e.err = 1'b1;
        end else if (acc) begin
            if (lat <= TMO) begin
                exp_stall = lat;
                if (!wr) begin
                    e.rdata = rval;
                    e.m2r   = 1'b1;
                end
            end else begin
                exp_stall = TMO + 1;
                e.err     = 1'b1;
            end
        end
        e.reg_en = ren & ~e.err;
        exp_q.push_back(e);

        mem_en_EX_MEM = en; mem_wr_EX_MEM = wr; alu_out_EX_MEM = addr; r2_EX_MEM = wdata;
        w1_reg_EX_MEM = w1; reg_en_EX_MEM = ren; halt_EX_MEM = hlt;
        stalls = 0; rdp = 0; wrp = 0;
        for (int k = 0; k < 64; k++) begin
            mem_done  = (k == lat) || (!acc && ($urandom_range(0, 3) == 0));
            mem_rdata = (k == lat) ? rval : 16'($urandom);
            #1;
            if (mem_rd) rdp++;
            if (mem_wr) wrp++;
            if (k == 0 && acc) begin
                chk("req_addr", mem_addr, addr);
                if (wr) chk("req_wdata", mem_wdata, wdata);
            end
            stl = stall_mem;
            @(posedge clk); #2;
            if (!stl) break;
            stalls++;
        end
        mem_done = 1'b0;
        chk("stall_cycles", stalls, exp_stall);
        chk("rd_pulses", rdp, (acc && !wr) ? 1 : 0);
        chk("wr_pulses", wrp, (acc && wr) ? 1 : 0);
    endtask

    // Monitor: decide bubble vs completion before the edge, compare MEM/WB after it.
    initial begin : monitor
        logic take, bub;
        wb_t  e;
        forever begin
            @(negedge clk); #3;
            take = rst & ~stall_mem;
            bub  = rst &  stall_mem;
            @(posedge clk); #1;
            if (take) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wb_unexpected: completion with empty scoreboard at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_alu",   alu_out_MEM_WB, e.alu);
                    chk("wb_rdata", rdata_MEM_WB, e.rdata);
                    chk("wb_ctrl", {w1_reg_MEM_WB, reg_en_MEM_WB, halt_MEM_WB, mem_to_reg_MEM_WB, err_MEM_WB},
                        {e.w1, e.reg_en, e.halt, e.m2r, e.err});
                end
            end else if (bub) begin
                chk("wb_bubble", {w1_reg_MEM_WB, reg_en_MEM_WB, halt_MEM_WB, alu_out_MEM_WB,
                                  rdata_MEM_WB, mem_to_reg_MEM_WB, err_MEM_WB}, 64'd0);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; mem_en_EX_MEM = 1'b0; mem_wr_EX_MEM = 1'b0; alu_out_EX_MEM = 16'd0;
        r2_EX_MEM = 16'd0; w1_reg_EX_MEM = 3'd0; reg_en_EX_MEM = 1'b0; halt_EX_MEM = 1'b0;
        mem_rdata = 16'd0; mem_done = 1'b0;
        #1;
        chk("reset_outputs", {stall_mem, mem_rd, mem_wr, w1_reg_MEM_WB, reg_en_MEM_WB, halt_MEM_WB,
                              alu_out_MEM_WB, rdata_MEM_WB, mem_to_reg_MEM_WB, err_MEM_WB}, 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;

        issue(1'b1, 1'b0, 16'h0010, 16'h0000, 3'd1, 1'b1, 1'b0, 0, 16'hBEEF);  // load hit
        issue(1'b1, 1'b1, 16'h0020, 16'h1234, 3'd2, 1'b0, 1'b0, 3, 16'h0000);  // store miss
        issue(1'b1, 1'b0, 16'h0021, 16'h0000, 3'd3, 1'b1, 1'b0, 0, 16'h0000);  // misaligned
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, 3'd4, 1'b1, 1'b0, 1000, 16'h7777); // timeout
        issue(1'b1, 1'b0, 16'h0032, 16'h0000, 3'd5, 1'b1, 1'b1, TMO, 16'hCAFE); // done on last cycle
        issue(1'b0, 1'b0, 16'h1111, 16'h2222, 3'd6, 1'b1, 1'b0, 0, 16'h0000);  // ALU op

        // Reset in WAIT after two wait cycles.
        mem_en_EX_MEM = 1'b1; mem_wr_EX_MEM = 1'b0; alu_out_EX_MEM = 16'h0040;
        w1_reg_EX_MEM = 3'd7; reg_en_EX_MEM = 1'b1; halt_EX_MEM = 1'b0; mem_done = 1'b0;
        #1;
        chk("rst_test_req", {mem_rd, stall_mem}, 64'd3);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", {stall_mem, mem_rd, mem_wr, w1_reg_MEM_WB, reg_en_MEM_WB, halt_MEM_WB,
                                  alu_out_MEM_WB, rdata_MEM_WB, mem_to_reg_MEM_WB, err_MEM_WB}, 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        issue(1'b0, 1'b0, 16'h5A5A, 16'h0000, 3'd5, 1'b1, 1'b0, 0, 16'h0000);

        for (int i = 0; i < 150; i++) begin
            int sel, lat;
            sel = $urandom_range(0, 9);
            if (sel < 4)       lat = 0;
            else if (sel < 7)  lat = $urandom_range(1, 4);
            else if (sel == 7) lat = TMO;
            else if (sel == 8) lat = TMO - 1;
            else               lat = 1000;
            issue($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 16'($urandom),
                  3'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, lat, 16'($urandom));
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
